test_signal_gen: RTL and testbench

Internal test-stimulus generator that sits directly upstream of the frequency meter. It produces the square wave `sigin` that the measurement stage counts, at one of four known frequencies selected by the board switches `testmode`. Frequency changes happen only at period boundaries, so the meter never sees a runt pulse or a truncated period. Each rising edge of `sigin` is also reported as a one-cycle tick, for bench cross-checking.

---
 rtl/test_signal_gen_pkg.sv | 12 +
 rtl/test_signal_gen_sync2.sv | 24 ++
 rtl/test_signal_gen.sv | 109 ++++++++++
 tb/tb_test_signal_gen.sv | 106 ++++++++++
 4 files changed

// File: rtl/test_signal_gen_pkg.sv
// Shared types for the test-stimulus generator: FSM state encoding and mode width.
package test_sig_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/test_signal_gen_sync2.sv
// Two-flop synchronizer for slow asynchronous inputs such as board switches.
module sync2 #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two back-to-back flops; both clear on synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/test_signal_gen.sv
// Square-wave stimulus for the frequency meter. Four selectable frequencies;
// mode and enable are only honoured at period boundaries so every period is whole.
module test_signal_gen
   import test_sig_pkg::*;
#(
   parameter int DIV_W = 16,
   parameter int HALF0 = 24000,
   parameter int HALF1 = 2400,
   parameter int HALF2 = 240,
   parameter int HALF3 = 24
) (
   input  logic              sysclk,
   input  logic              resetb,
   input  logic [MODE_W-1:0] testmode,
   input  logic              en,
   output logic              sigin,
   output logic              period_tick,
   output logic [MODE_W-1:0] mode_active
);

   // Counter reload values are HALF-1 because the load cycle itself counts as one.
   localparam logic [DIV_W-1:0] RL0 = DIV_W'(HALF0 - 1);
   localparam logic [DIV_W-1:0] RL1 = DIV_W'(HALF1 - 1);
   localparam logic [DIV_W-1:0] RL2 = DIV_W'(HALF2 - 1);
   localparam logic [DIV_W-1:0] RL3 = DIV_W'(HALF3 - 1);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   state_t            state;
   logic [DIV_W-1:0]  cnt;
   logic [MODE_W-1:0] tm_s;
   logic [DIV_W-1:0]  reload_new;
   logic [DIV_W-1:0]  reload_cur;

   sync2 #(.WIDTH(MODE_W)) u_sync (
      .clk (sysclk),
      .rst (resetb),
      .d   (testmode),
      .q   (tm_s)
   );

   function automatic logic [DIV_W-1:0] reload_of(input logic [MODE_W-1:0] m);
      case (m)
         2'd0:    reload_of = RL0;
         2'd1:    reload_of = RL1;
         2'd2:    reload_of = RL2;
         default: reload_of = RL3;
      endcase
   endfunction

   // Reload for a new period uses the freshly synchronized mode; the LOW half
   // uses the mode latched at period start so a mid-period switch is ignored.
   always_comb begin
      reload_new = reload_of(tm_s);
      reload_cur = reload_of(mode_active);
   end

   // Period FSM: IDLE -> HIGH -> LOW -> (HIGH | IDLE), with a shared down-counter.
   always_ff @(posedge sysclk) begin
      if (resetb) begin
         state       <= IDLE;
         cnt         <= '0;
         sigin       <= 1'b0;
         period_tick <= 1'b0;
         mode_active <= '0;
      end else begin
         period_tick <= 1'b0;
         case (state)
            IDLE: begin
               sigin <= 1'b0;
               if (en) begin
                  state       <= HIGH;
                  mode_active <= tm_s;
                  cnt         <= reload_new;
                  sigin       <= 1'b1;
                  period_tick <= 1'b1;
               end
            end
            HIGH: begin
               if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else begin
                  state <= LOW;
                  cnt   <= reload_cur;
                  sigin <= 1'b0;
               end
            end
            LOW: begin
               if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else if (en) begin
                  state       <= HIGH;
                  mode_active <= tm_s;
                  cnt         <= reload_new;
                  sigin       <= 1'b1;
                  period_tick <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               sigin <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_test_signal_gen.sv
// Directed bench for test_signal_gen with HALF = 3/5/8/1. Expected waveforms are
// hand-written per cycle as strings of '0'/'1', one character per clock edge.
module tb_test_signal_gen;

   logic       sysclk = 1'b0;
   logic       resetb;
   logic [1:0] testmode;
   logic       en;
   logic       sigin;
   logic       period_tick;
   logic [1:0] mode_active;

   int total = 0;
   int bad   = 0;

   test_signal_gen #(
      .DIV_W (16),
      .HALF0 (3),
      .HALF1 (5),
      .HALF2 (8),
      .HALF3 (1)
   ) dut (
      .sysclk      (sysclk),
      .resetb      (resetb),
      .testmode    (testmode),
      .en          (en),
      .sigin       (sigin),
      .period_tick (period_tick),
      .mode_active (mode_active)
   );

   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge per character; check sigin, period_tick and mode_active.
   task automatic run_seq(input string tag, input string s, input string t, input logic [1:0] m);
      for (int i = 0; i < s.len(); i++) begin
         @(posedge sysclk);
         #1;
         chk($sformatf("%s.sig%0d", tag, i), 32'(sigin), (s[i] == 8'h31) ? 32'd1 : 32'd0);
         chk($sformatf("%s.tick%0d", tag, i), 32'(period_tick), (t[i] == 8'h31) ? 32'd1 : 32'd0);
         chk($sformatf("%s.mode%0d", tag, i), 32'(mode_active), 32'(m));
      end
   endtask

   initial begin
      resetb   = 1'b1;
      en       = 1'b1;
      testmode = 2'd0;

      // Reset state
      run_seq("rst", "000", "000", 2'd0);
      resetb = 1'b0;

      // 1: mode 0, 3 high / 3 low, tick every 6 cycles
      run_seq("s1", "111000111000", "100000100000", 2'd0);

      // 2: switch to mode 1 during HIGH; current period stays 3/3
      run_seq("s2a", "1", "1", 2'd0);
      testmode = 2'd1;
      run_seq("s2b", "11000", "00000", 2'd0);
      run_seq("s2c", "1111100000", "1000000000", 2'd1);

      // 4: mode 3 toggles every cycle
      testmode = 2'd3;
      run_seq("s4a", "1111100000", "1000000000", 2'd1);
      run_seq("s4b", "101010", "101010", 2'd3);

      // 5: back to mode 0, drop en in second HIGH cycle, then re-enable
      testmode = 2'd0;
      run_seq("s5a", "10", "10", 2'd3);
      run_seq("s5b", "1", "1", 2'd0);
      run_seq("s5c", "1", "0", 2'd0);
      en = 1'b0;
      run_seq("s5d", "1000000", "0000000", 2'd0);
      en = 1'b1;
      run_seq("s5e", "111000", "100000", 2'd0);

      // 3: testmode 2 held through reset; first period is still mode 0
      testmode = 2'd2;
      resetb   = 1'b1;
      run_seq("s3r", "000", "000", 2'd0);
      resetb = 1'b0;
      run_seq("s3a", "111000", "100000", 2'd0);
      run_seq("s3b", "1111111100000000", "1000000000000000", 2'd2);

      // 6: one-cycle reset pulse mid-HIGH in mode 2
      run_seq("s6a", "111", "100", 2'd2);
      resetb = 1'b1;
      run_seq("s6r", "0", "0", 2'd0);
      resetb = 1'b0;
      run_seq("s6b", "111000", "100000", 2'd0);
      run_seq("s6c", "1", "1", 2'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
